regbank_writeback: RTL and testbench

Write-side front end for the 16 x 32-bit RegisterBank. Buffers register write requests from the execute/load stages in a small in-order FIFO and drains one entry per cycle into the bank's `dest`/`Din` write port. Provides forwarding of pending, not-yet-committed values to the bank's two read ports (`srcadd1`/`srcadd2`), so readers never see stale data while writes are queued.

---
 rtl/regbank_pkg.sv | 14 +
 rtl/wb_fwd_match.sv | 41 ++++
 rtl/regbank_writeback.sv | 122 ++++++++++++
 tb/tb_regbank_writeback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the 16 x 32-bit RegisterBank and its write-back
// front end.
package regbank_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup for one RegisterBank read port.
// Scans the pending write entries from oldest (rd_ptr) to youngest, so the
// last match found is the youngest one and wins.
//   ent_dest/ent_data : FIFO storage
//   valid             : per-slot occupancy mask
//   rd_ptr/count      : head slot and number of pending entries
//   addr              : read address to look up
//   hit/data          : match flag and youngest matching value (0 on miss)
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regbank_pkg::ADDR_W,
  parameter int DATA_W = regbank_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [ADDR_W-1:0] ent_dest [DEPTH],
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && valid[idx] && (ent_dest[idx] == addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/regbank_writeback.sv
// Write-side front end of the RegisterBank: an in-order FIFO of pending
// register writes drained one entry per cycle into the bank write port,
// plus forwarding of pending values to the bank's two read ports.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : write request handshake (in_dest, in_data)
//   flush                    : discard all pending entries
//   wb_stall                 : hold the head entry this cycle
//   wr_en/dest/Din           : bank write port (head entry)
//   srcadd1/srcadd2          : bank read addresses
//   fwd*_hit/fwd*_data       : youngest pending value for each read address
//   count/full/empty         : occupancy
module regbank_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regbank_pkg::ADDR_W,
  parameter int DATA_W = regbank_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              wb_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] Din,
  input  logic [ADDR_W-1:0] srcadd1,
  input  logic [ADDR_W-1:0] srcadd2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DEPTH-1:0]  valid;
  logic              push;
  logic [PTR_W-1:0]  offset;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Ready depends only on state, so a pop in the same cycle never frees a
  // slot for a push and wb_stall has no path to in_ready.
  assign in_ready = !rst && (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && !flush;

  // Gated by rst as well so entries discarded by a reset never commit.
  assign wr_en = !rst && !empty && !wb_stall && !flush;

  assign dest = empty ? '0 : dest_mem[rd_ptr];
  assign Din  = empty ? '0 : data_mem[rd_ptr];

  always_comb begin
    valid  = '0;
    offset = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset   = PTR_W'(j) - rd_ptr;
      valid[j] = ({1'b0, offset} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (wr_en) rd_ptr <= rd_ptr + 1'b1;
      case ({push, wr_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the occupancy mask qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= in_dest;
      data_mem[wr_ptr] <= in_data;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
    .ent_dest (dest_mem),
    .ent_data (data_mem),
    .valid    (valid),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .addr     (srcadd1),
    .hit      (fwd1_hit),
    .data     (fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
    .ent_dest (dest_mem),
    .ent_data (data_mem),
    .valid    (valid),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .addr     (srcadd2),
    .hit      (fwd2_hit),
    .data     (fwd2_data)
  );

endmodule

// File: tb/tb_regbank_writeback.sv
module tb_regbank_writeback;
  import regbank_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              wb_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] Din;
  logic [ADDR_W-1:0] srcadd1;
  logic [ADDR_W-1:0] srcadd2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  regbank_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .flush     (flush),
    .wb_stall  (wb_stall),
    .wr_en     (wr_en),
    .dest      (dest),
    .Din       (Din),
    .srcadd1   (srcadd1),
    .srcadd2   (srcadd2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pending writes in commit order.
  wb_entry_t pend [$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fwd_model(input logic [ADDR_W-1:0] a, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].dest == a) begin
        h = 1'b1;
        d = pend[i].data;
        break;
      end
    end
  endtask

  // One clock cycle with the inputs already set: check outputs at the
  // falling edge, advance the model, then move past the rising edge.
  task automatic cyc();
    logic              exp_ready;
    logic              exp_wr;
    logic              h;
    logic [DATA_W-1:0] d;
    int                n;
    wb_entry_t         e;
    @(negedge clk);
    n         = pend.size();
    exp_ready = !rst && (n < DEPTH);
    exp_wr    = !rst && (n > 0) && !wb_stall && !flush;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("wr_en",    64'(wr_en),    64'(exp_wr));
    chk("count",    64'(count),    64'(n));
    chk("full",     64'(full),     64'(n == DEPTH));
    chk("empty",    64'(empty),    64'(n == 0));
    if (n > 0) begin
      chk("dest", 64'(dest), 64'(pend[0].dest));
      chk("Din",  64'(Din),  64'(pend[0].data));
    end else begin
      chk("dest_idle", 64'(dest), 64'd0);
      chk("Din_idle",  64'(Din),  64'd0);
    end
    fwd_model(srcadd1, h, d);
    chk("fwd1_hit",  64'(fwd1_hit),  64'(h));
    chk("fwd1_data", 64'(fwd1_data), 64'(d));
    fwd_model(srcadd2, h, d);
    chk("fwd2_hit",  64'(fwd2_hit),  64'(h));
    chk("fwd2_data", 64'(fwd2_data), 64'(d));
    if (exp_wr) void'(pend.pop_front());
    if (rst || flush) begin
      pend.delete();
    end else if (in_valid && exp_ready) begin
      e.dest = in_dest;
      e.data = in_data;
      pend.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_dest  = a;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
    drive(1'b0, '0, '0);
    srcadd1 = '0; srcadd2 = '0;

    // Reset
    cyc();
    cyc();
    rst = 1'b0;

    // Single write, forwarded before commit, then committed
    drive(1'b1, 4'd1, 32'd1);
    cyc();
    drive(1'b0, '0, '0);
    srcadd1 = 4'd1;
    cyc();
    cyc();
    chk("empty_after_commit", 64'(empty), 64'd1);

    // Fill to full under stall, fifth push refused, ordered drain
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(2 + i), 32'hA + 32'(i));
      cyc();
    end
    drive(1'b1, 4'd6, 32'hEE);
    srcadd1 = 4'd4; srcadd2 = 4'd9;
    cyc();
    chk("full_held", 64'(full), 64'd1);
    drive(1'b0, '0, '0);
    wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) cyc();

    // Duplicate destination, youngest forwarded, both committed in order
    wb_stall = 1'b1;
    drive(1'b1, 4'd3, 32'h11);
    cyc();
    drive(1'b1, 4'd3, 32'h22);
    srcadd2 = 4'd3;
    cyc();
    drive(1'b0, '0, '0);
    cyc();
    chk("fwd2_youngest", 64'(fwd2_data), 64'h22);
    wb_stall = 1'b0;
    cyc();
    cyc();
    cyc();

    // Continuous traffic at count=2 across pointer wrap
    wb_stall = 1'b1;
    drive(1'b1, 4'd7, 32'h100);
    cyc();
    drive(1'b1, 4'd8, 32'h101);
    cyc();
    wb_stall = 1'b0;
    srcadd1 = 4'd5;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ADDR_W'(i), 32'h200 + 32'(i));
      srcadd2 = ADDR_W'(i);
      cyc();
      chk("count_steady", 64'(count), 64'd2);
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cyc();

    // Flush at count=3 with a simultaneous push
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(10 + i), 32'h300 + 32'(i));
      cyc();
    end
    wb_stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 4'd15, 32'h3FF);
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    cyc();
    chk("count_after_flush", 64'(count), 64'd0);
    cyc();

    // Reset with two entries pending
    wb_stall = 1'b1;
    drive(1'b1, 4'd4, 32'h400);
    cyc();
    drive(1'b1, 4'd5, 32'h401);
    srcadd1 = 4'd4; srcadd2 = 4'd5;
    cyc();
    drive(1'b0, '0, '0);
    wb_stall = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
